// File: rtl/lvds_video_pkg.sv
// Shared definitions for the LVDS raster/test-pattern source.
// - pattern mode encodings
// - colour-bar table (one on/off bit per channel, expanded to full depth by the user)
// - video word packing: {hsync, vsync, data_en, green, red, blue}
package lvds_video_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_RAMP  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_FADE  = 3'd4
  } pat_e;

  localparam int unsigned NUM_BARS = 8;
  // Widest packed word (CB=8); narrower depths use the low 3*CB+3 bits.
  localparam int unsigned VWORD_MAX = 27;

  // Returns {r,g,b} on/off for bars W,Y,C,G,M,R,B,K.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    unique case (idx)
      3'd0: rgb = 3'b111;
      3'd1: rgb = 3'b110;
      3'd2: rgb = 3'b011;
      3'd3: rgb = 3'b010;
      3'd4: rgb = 3'b101;
      3'd5: rgb = 3'b100;
      3'd6: rgb = 3'b001;
      3'd7: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // Packs channels of depth cb (colour inputs zero-extended to 8 bits) into the low bits.
  function automatic logic [VWORD_MAX-1:0] pack_video(input logic hs, input logic vs,
                                                      input logic de, input logic [7:0] g,
                                                      input logic [7:0] r, input logic [7:0] b,
                                                      input int unsigned cb);
    logic [VWORD_MAX-1:0] w;
    w = {24'd0, hs, vs, de};
    w = (w << cb) | {19'd0, g};
    w = (w << cb) | {19'd0, r};
    w = (w << cb) | {19'd0, b};
    return w;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster counters and timing decode.
// Ports:
//   i_clk, i_rst (sync, active-high), i_enable (0 holds counters at 0,0)
//   o_h_cnt / o_v_cnt  current raster position
//   o_active           position lies in visible area
//   o_hsync_on/o_vsync_on  position lies in the sync pulse (polarity applied by the user)
//   o_sof              enabled and at (0,0)
//   o_wrap             enabled and at the last pixel of the frame
//   o_line_end         at the last pixel of a line
module video_timing_counter #(
  parameter int unsigned H_ACTIVE = 1366,
  parameter int unsigned H_FP     = 30,
  parameter int unsigned H_SYNC   = 114,
  parameter int unsigned H_BP     = 30,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 4,
  parameter int unsigned HW       = 11,
  parameter int unsigned VW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hsync_on,
  output logic          o_vsync_on,
  output logic          o_sof,
  output logic          o_wrap,
  output logic          o_line_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_h_cnt == HLast);
  assign w_frame_end = w_line_end && (r_v_cnt == VLast);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt    = r_h_cnt;
  assign o_v_cnt    = r_v_cnt;
  assign o_active   = (r_h_cnt < HActive) && (r_v_cnt < VActive);
  assign o_hsync_on = (r_h_cnt >= HsStart) && (r_h_cnt < HsEnd);
  // Decoded from v_cnt alone, so vsync spans whole lines and toggles at h_cnt==0.
  assign o_vsync_on = (r_v_cnt >= VsStart) && (r_v_cnt < VsEnd);
  assign o_sof      = i_enable && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_wrap     = i_enable && w_frame_end;
  assign o_line_end = w_line_end;

endmodule

// File: rtl/lvds_video_timing_gen.sv
// Raster timing and test-pattern source feeding the 7:1 LVDS serialiser.
// Ports:
//   i_pixel_clk  sole clock;  i_rst  sync active-high reset
//   i_enable     0 holds raster at (0,0) with outputs blanked
//   i_mode       pattern select, latched at frame start
//   i_solid_rgb  {g,r,b} colour for the solid pattern
//   o_hsync/o_vsync/o_data_en, o_red/o_green/o_blue  registered video
//   o_video_word {hsync,vsync,data_en,green,red,blue}
//   o_sof        1-cycle pulse with pixel (0,0);  o_frame_cnt  completed frames
module lvds_video_timing_gen
  import lvds_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1366,
  parameter int unsigned H_FP     = 30,
  parameter int unsigned H_SYNC   = 114,
  parameter int unsigned H_BP     = 30,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 4,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned CB       = 6,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic              i_pixel_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [2:0]        i_mode,
  input  logic [3*CB-1:0]   i_solid_rgb,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_data_en,
  output logic [CB-1:0]     o_red,
  output logic [CB-1:0]     o_green,
  output logic [CB-1:0]     o_blue,
  output logic [3*CB+2:0]   o_video_word,
  output logic              o_sof,
  output logic [15:0]       o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BW      = H_ACTIVE / NUM_BARS;
  localparam logic [HW-1:0] BwLast = HW'(BW - 1);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      !(CB == 6 || CB == 8) || BW == 0) begin : g_bad_param
    $error("lvds_video_timing_gen: zero porch/sync, H_ACTIVE < 8, or CB not 6/8");
  end

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_active, w_hsync_on, w_vsync_on, w_sof, w_wrap, w_line_end;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_counter (
    .i_clk      (i_pixel_clk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .o_h_cnt    (w_h_cnt),
    .o_v_cnt    (w_v_cnt),
    .o_active   (w_active),
    .o_hsync_on (w_hsync_on),
    .o_vsync_on (w_vsync_on),
    .o_sof      (w_sof),
    .o_wrap     (w_wrap),
    .o_line_end (w_line_end)
  );

  // Bar index tracks h_cnt without a divider: step every BW pixels, last bar holds to line end.
  logic [HW-1:0] r_bar_px;
  logic [2:0]    r_bar_idx;

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst || !i_enable || w_line_end) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_idx != 3'd7) begin
      if (r_bar_px == BwLast) begin
        r_bar_px  <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_px <= r_bar_px + 1'b1;
      end
    end
  end

  logic [2:0]    r_mode;
  logic [15:0]   r_frame_cnt;
  logic          r_hsync, r_vsync, r_data_en, r_sof;
  logic [CB-1:0] r_red, r_green, r_blue;

  logic [2:0]    w_mode;
  logic [2:0]    w_bar;
  logic          w_chk;
  logic [CB-1:0] w_red, w_green, w_blue;

  always_comb begin
    // Pixel (0,0) must already show the newly selected mode.
    w_mode  = w_sof ? i_mode : r_mode;
    w_bar   = bar_rgb(r_bar_idx);
    w_chk   = w_h_cnt[CHK_LOG2] ^ w_v_cnt[CHK_LOG2];
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (w_mode)
      PAT_SOLID: {w_green, w_red, w_blue} = i_solid_rgb;
      PAT_BARS: begin
        w_red   = {CB{w_bar[2]}};
        w_green = {CB{w_bar[1]}};
        w_blue  = {CB{w_bar[0]}};
      end
      PAT_RAMP: begin
        w_red   = CB'(w_h_cnt);
        w_green = CB'(w_h_cnt);
        w_blue  = CB'(w_h_cnt);
      end
      PAT_CHECK: begin
        w_red   = {CB{w_chk}};
        w_green = {CB{w_chk}};
        w_blue  = {CB{w_chk}};
      end
      PAT_FADE: begin
        w_red   = r_frame_cnt[CB-1:0];
        w_green = ~r_frame_cnt[CB-1:0];
      end
      default: ;
    endcase
    if (!w_active) begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst || !i_enable) begin
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
      r_data_en <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_sof     <= 1'b0;
      if (i_rst) begin
        r_mode      <= '0;
        r_frame_cnt <= '0;
      end
    end else begin
      r_hsync   <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
      r_vsync   <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
      r_data_en <= w_active;
      r_red     <= w_red;
      r_green   <= w_green;
      r_blue    <= w_blue;
      r_sof     <= w_sof;
      if (w_sof) r_mode <= i_mode;
      if (w_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  logic [VWORD_MAX-1:0] w_word;
  assign w_word = pack_video(r_hsync, r_vsync, r_data_en, 8'(r_green), 8'(r_red), 8'(r_blue),
                             CB);

  if (3 * CB + 3 < VWORD_MAX) begin : g_word_hi
    logic w_unused_word_hi;
    assign w_unused_word_hi = ^w_word[VWORD_MAX-1:3*CB+3];
  end

  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_data_en    = r_data_en;
  assign o_red        = r_red;
  assign o_green      = r_green;
  assign o_blue       = r_blue;
  assign o_sof        = r_sof;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_video_word = w_word[3*CB+2:0];

endmodule
